// File: rtl/uart_pkg.sv
// Shared protocol constants, FSM state encoding and width helper for the UART
// register responder.
package uart_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
    localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_EXEC,
        ST_SEND
    } state_e;

    function automatic int clog2(input int value);
        int bits = 0;
        int rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_reg_file.sv
// DEPTH x DBITS register file: synchronous write, combinational read, register 0
// tapped out as ctrl, top address is a read-only window onto status_i.
module uart_reg_file
    import uart_pkg::*;
#(
    parameter  int DBITS = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [DBITS-1:0] wdata_i,
    input  logic [DBITS-1:0] status_i,
    output logic [DBITS-1:0] rdata_o,
    output logic [DBITS-1:0] ctrl_o
);

    localparam logic [AW-1:0] STATUS_ADDR = AW'(DEPTH - 1);

    logic [DBITS-1:0] regs_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order. The array is reset
    // too: it is built from flops and software expects all registers to read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (addr_i != STATUS_ADDR)) begin
            regs_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = (addr_i == STATUS_ADDR) ? status_i : regs_q[addr_i];
    assign ctrl_o  = regs_q[0];

endmodule

// File: rtl/uart_reg_responder.sv
// Decodes 'W' addr data / 'R' addr commands from the UART rx FIFO and answers one
// byte per command into the tx FIFO. Optional inter-byte timeout: UART_RESP_TIMEOUT_EN.
module uart_reg_responder
    import uart_pkg::*;
#(
    parameter int DBITS          = 8,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [DBITS-1:0] r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic [DBITS-1:0] w_data,
    output logic             wr_uart,
    output logic [DBITS-1:0] ctrl_reg,
    input  logic [DBITS-1:0] status_in,
    output logic             cmd_err
);

    localparam int AW = clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AW > DBITS) begin : g_bad_depth
        $error("DEPTH must be a power of two between 2 and 2**DBITS");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e           state_q, state_d;
    logic [DBITS-1:0] opcode_q, opcode_d;
    logic [DBITS-1:0] addr_q, addr_d;
    logic [DBITS-1:0] data_q, data_d;
    logic [DBITS-1:0] resp_q, resp_d;
    logic             cmd_err_q, cmd_err_d;
    logic             rf_we;
    logic [DBITS-1:0] rf_rdata;
    logic             pop;
    logic             waiting;
    logic             is_write;
    logic             addr_ok;
    logic             tmo_hit;

    assign waiting  = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
    assign pop      = !reset && !rx_empty && ((state_q == ST_IDLE) || waiting);
    assign rd_uart  = pop;
    assign wr_uart  = !reset && (state_q == ST_SEND) && !tx_full;
    assign w_data   = resp_q;
    assign cmd_err  = cmd_err_q;
    assign is_write = (opcode_q == DBITS'(OP_WR));
    assign addr_ok  = ((addr_q >> AW) == '0);

`ifdef UART_RESP_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = waiting && rx_empty && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Any pop or any state outside the byte-wait states leaves the counter at zero.
    always_comb begin
        tmo_cnt_d = '0;
        if (waiting && rx_empty && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    uart_reg_file #(
        .DBITS (DBITS),
        .DEPTH (DEPTH)
    ) u_reg_file (
        .clk      (clk),
        .reset    (reset),
        .we_i     (rf_we),
        .addr_i   (addr_q[AW-1:0]),
        .wdata_i  (data_q),
        .status_i (status_in),
        .rdata_o  (rf_rdata),
        .ctrl_o   (ctrl_reg)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        opcode_d  = opcode_q;
        addr_d    = addr_q;
        data_d    = data_q;
        resp_d    = resp_q;
        cmd_err_d = 1'b0;
        rf_we     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    opcode_d = r_data;
                    if (r_data == DBITS'(OP_WR) || r_data == DBITS'(OP_RD)) begin
                        state_d = ST_GET_ADDR;
                    end else begin
                        resp_d    = DBITS'(RSP_ERR);
                        cmd_err_d = 1'b1;
                        state_d   = ST_SEND;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (pop) begin
                    addr_d  = r_data;
                    state_d = is_write ? ST_GET_DATA : ST_EXEC;
                end else if (tmo_hit) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (pop) begin
                    data_d  = r_data;
                    state_d = ST_EXEC;
                end else if (tmo_hit) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_SEND;
                // An out-of-range write has already consumed its data byte by now.
                if (!addr_ok) begin
                    resp_d    = DBITS'(RSP_ERR);
                    cmd_err_d = 1'b1;
                end else if (is_write) begin
                    rf_we  = 1'b1;
                    resp_d = DBITS'(RSP_ACK);
                end else begin
                    resp_d = rf_rdata;
                end
            end
            ST_SEND: begin
                if (!tx_full) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            resp_q    <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
            cmd_err_q <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder: FWFT rx/tx FIFO models around the DUT,
// hand-computed responses, latencies and pulse counts.
`timescale 1ns/1ps
module tb_uart_reg_responder;

    localparam int DBITS      = 8;
    localparam int DEPTH      = 16;
    localparam int TB_TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] ctrl_reg;
    logic [7:0] status_in;
    logic       cmd_err;

    logic [7:0] rx_buf [256];
    int         rx_wr = 0;
    int         rx_rd = 0;
    logic [7:0] tx_buf [256];
    int         tx_cnt = 0;
    int         rd_cnt = 0;
    int         err_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    logic       pop_p;
    logic       push_p;
    logic [7:0] wd_p;

    logic [7:0] exp_seq [6] = '{8'h3F, 8'h3F, 8'h00, 8'h9E, 8'h4B, 8'h9E};

    assign rx_empty = (rx_wr == rx_rd);
    assign r_data   = rx_buf[rx_rd % 256];

    always #5 clk = ~clk;

    uart_reg_responder #(
        .DBITS          (DBITS),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .ctrl_reg  (ctrl_reg),
        .status_in (status_in),
        .cmd_err   (cmd_err)
    );

    // FIFO model: strobes sampled mid-cycle, applied just after the next edge.
    always begin
        @(negedge clk);
        pop_p  = rd_uart;
        push_p = wr_uart;
        wd_p   = w_data;
        if (rd_uart) rd_cnt++;
        if (cmd_err) err_cnt++;
        @(posedge clk);
        #1;
        if (pop_p) rx_rd++;
        if (push_p) begin
            tx_buf[tx_cnt % 256] = wd_p;
            tx_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_buf[rx_wr % 256] = b;
        rx_wr++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_cnt < n && k < 200) begin
            step();
            k++;
        end
        check("wait_tx", tx_cnt, n);
    endtask

    task automatic measure(output int c);
        c = 0;
        while (c < 20) begin
            step();
            c++;
            if (wr_uart) break;
        end
    endtask

    initial begin
        int lat;
        int t0;
        int r0;
        int e0;

        reset     = 1'b1;
        tx_full   = 1'b0;
        status_in = 8'h9E;
        push_rx(8'h52);
        step();
        step();
        check("rst_rd_uart", rd_uart, 1'b0);
        check("rst_wr_uart", wr_uart, 1'b0);
        check("rst_w_data", w_data, 8'h00);
        check("rst_ctrl_reg", ctrl_reg, 8'h00);
        check("rst_cmd_err", cmd_err, 1'b0);

        // The 'R' byte survives reset in the rx FIFO; completing it reads reg 0.
        reset = 1'b0;
        push_rx(8'h00);
        wait_tx(1);
        check("rx_kept_over_reset", tx_buf[0], 8'h00);

        // Write then read, with cycle-exact latency.
        t0 = tx_cnt;
        r0 = rd_cnt;
        e0 = err_cnt;
        push_rx(8'h57); push_rx(8'h03); push_rx(8'hA5);
        measure(lat);
        check("wr_latency", lat, 4);
        step();
        push_rx(8'h52); push_rx(8'h03);
        measure(lat);
        check("rd_latency", lat, 3);
        step();
        check("wr_rd_count", tx_cnt - t0, 2);
        check("wr_resp", tx_buf[t0], 8'h4B);
        check("rd_resp", tx_buf[t0 + 1], 8'hA5);
        check("wr_rd_pops", rd_cnt - r0, 5);
        check("wr_rd_no_err", err_cnt - e0, 0);

        // Control tap updates on the edge leaving EXEC.
        t0 = tx_cnt;
        push_rx(8'h57); push_rx(8'h00); push_rx(8'h3C);
        step(); step(); step();
        check("ctrl_in_exec", ctrl_reg, 8'h00);
        step();
        check("ctrl_after_exec", ctrl_reg, 8'h3C);
        check("ctrl_wr_uart", wr_uart, 1'b1);
        check("ctrl_w_data", w_data, 8'h4B);
        step();
        check("ctrl_push", tx_cnt - t0, 1);

        // Unknown opcode: error response and a single-cycle cmd_err.
        e0 = err_cnt;
        push_rx(8'h41);
        step();
        check("badop_cmd_err", cmd_err, 1'b1);
        check("badop_wr_uart", wr_uart, 1'b1);
        check("badop_w_data", w_data, 8'h3F);
        step();
        check("badop_err_clear", cmd_err, 1'b0);
        check("badop_err_pulses", err_cnt - e0, 1);

        // Range errors (read and write), status window, write to status ignored.
        t0 = tx_cnt;
        e0 = err_cnt;
        push_rx(8'h52); push_rx(8'h20);
        push_rx(8'h57); push_rx(8'h11); push_rx(8'h77);
        push_rx(8'h52); push_rx(8'h01);
        push_rx(8'h52); push_rx(8'h0F);
        push_rx(8'h57); push_rx(8'h0F); push_rx(8'h55);
        push_rx(8'h52); push_rx(8'h0F);
        wait_tx(t0 + 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("range_seq[%0d]", i), tx_buf[(t0 + i) % 256], exp_seq[i]);
        end
        check("range_err_pulses", err_cnt - e0, 2);

        // Backpressure: stall in SEND, no pops, then exactly one push per command.
        push_rx(8'h57); push_rx(8'h01); push_rx(8'hC3);
        wait_tx(tx_cnt + 1);
        t0 = tx_cnt;
        r0 = rd_cnt;
        tx_full = 1'b1;
        push_rx(8'h52); push_rx(8'h01);
        push_rx(8'h52); push_rx(8'h03);
        repeat (12) step();
        check("bp_wr_uart", wr_uart, 1'b0);
        check("bp_no_push", tx_cnt - t0, 0);
        check("bp_pops", rd_cnt - r0, 2);
        check("bp_rx_pending", rx_wr - rx_rd, 2);
        tx_full = 1'b0;
        wait_tx(t0 + 2);
        check("bp_resp0", tx_buf[t0 % 256], 8'hC3);
        check("bp_resp1", tx_buf[(t0 + 1) % 256], 8'hA5);
        step(); step();
        check("bp_push_total", tx_cnt - t0, 2);
        check("bp_pops_total", rd_cnt - r0, 4);

        // Reset in GET_DATA discards the partial write.
        t0 = tx_cnt;
        e0 = err_cnt;
        push_rx(8'h57); push_rx(8'h02);
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_ctrl", ctrl_reg, 8'h00);
        push_rx(8'h52); push_rx(8'h02);
        wait_tx(t0 + 1);
        check("midrst_resp", tx_buf[t0 % 256], 8'h00);
        step(); step(); step();
        check("midrst_push_total", tx_cnt - t0, 1);
        check("midrst_no_err", err_cnt - e0, 0);

        // Opcode followed by a long gap.
        t0 = tx_cnt;
        e0 = err_cnt;
        push_rx(8'h57);
        repeat (60) step();
        check("gap_no_push", tx_cnt - t0, 0);
`ifdef UART_RESP_TIMEOUT_EN
        check("tmo_err_pulse", err_cnt - e0, 1);
        push_rx(8'h52); push_rx(8'h00);
        wait_tx(t0 + 1);
        check("tmo_next_cmd", tx_buf[t0 % 256], 8'h00);
`else
        check("gap_no_err", err_cnt - e0, 0);
        push_rx(8'h04); push_rx(8'h66);
        wait_tx(t0 + 1);
        check("gap_wr_resp", tx_buf[t0 % 256], 8'h4B);
        push_rx(8'h52); push_rx(8'h04);
        wait_tx(t0 + 2);
        check("gap_rd_resp", tx_buf[(t0 + 1) % 256], 8'h66);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
